// File: rtl/act_backward_block.sv
`default_nettype none
// ============================================================================
// Module  : act_backward_block
// Brief   : Activation-layer backward pass (tanh / sigmoid derivative times
//           upstream gradient), LANES elements per cycle, 3-stage pipeline.
//           Optional build macro ACT_BWD_SAT_EN saturates the final product.
// Rev     : 1.0 - initial release
// ============================================================================
module act_backward_block #(
  parameter int DIM     = 32,
  parameter int LANES   = 4,
  parameter int N_LEN   = 16,
  parameter int F_LEN   = 8,
  parameter int N_LEN_W = 16,
  parameter int F_LEN_W = 13
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     clear,
  input  logic                     mode,
  input  logic [DIM*N_LEN-1:0]     d,
  input  logic [DIM*N_LEN_W-1:0]   q_forward,
  output logic                     busy,
  output logic                     valid,
  output logic [DIM*N_LEN-1:0]     q_backward
);

  localparam int c_groups = DIM / LANES;
  localparam int c_gw     = (c_groups > 1) ? $clog2(c_groups) : 1;
  localparam logic [c_gw-1:0] c_last = c_gw'(c_groups - 1);
  localparam logic signed [N_LEN_W-1:0] c_one = N_LEN_W'(1 << F_LEN_W);
  // d*deriv carries F_LEN+F_LEN_W fraction bits; drop back to F_LEN
  localparam int c_shift  = (F_LEN + F_LEN_W) - F_LEN;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [c_gw-1:0] r_g;
  logic            r_issue;
  logic            r_mode;

  logic            r_s1_vld, r_s2_vld, r_s3_vld;
  logic [c_gw-1:0] r_s1_grp, r_s2_grp, r_s3_grp;
  logic            w_last_write;

  logic [N_LEN_W-1:0] w_qf     [c_groups][LANES];
  logic [N_LEN-1:0]   w_d      [c_groups][LANES];
  logic [N_LEN-1:0]   w_s3_res [LANES];

  assign w_last_write = r_s3_vld && (r_s3_grp == c_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_g     <= '0;
      r_issue <= 1'b0;
      r_mode  <= 1'b0;
      busy    <= 1'b0;
      valid   <= 1'b0;
    end else if (clear) begin
      r_state <= ST_IDLE;
      r_g     <= '0;
      r_issue <= 1'b0;
      busy    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_g     <= '0;
            r_issue <= 1'b1;
            r_mode  <= mode;
          end
        end
        ST_RUN: begin
          if (r_g != c_last) r_g <= r_g + 1'b1;
          r_issue <= r_issue && (r_g != c_last);
          if (w_last_write) begin
            r_state <= ST_DONE;
            busy    <= 1'b0;
            valid   <= 1'b1;
          end else begin
            busy    <= 1'b1;
            valid   <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Control tokens ride alongside the lane data; clear flushes them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s3_vld <= 1'b0;
      r_s1_grp <= '0;
      r_s2_grp <= '0;
      r_s3_grp <= '0;
    end else if (clear) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s3_vld <= 1'b0;
    end else begin
      r_s1_vld <= (r_state == ST_RUN) && r_issue;
      r_s2_vld <= r_s1_vld;
      r_s3_vld <= r_s2_vld;
      r_s1_grp <= r_g;
      r_s2_grp <= r_s1_grp;
      r_s3_grp <= r_s2_grp;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [N_LEN_W-1:0]       w_q;
    logic signed [2*N_LEN_W-1:0]     w_qx, w_sq_full;
    logic signed [N_LEN-1:0]         w_dl;
    logic signed [N_LEN+N_LEN_W-1:0] w_dx, w_derivx, w_prod;
    logic        [N_LEN-1:0]         w_res;
    logic signed [N_LEN_W-1:0]       r_s1_q, r_s1_sq, r_s2_deriv;
    logic        [N_LEN-1:0]         r_s3_res;

    assign w_q       = w_qf[r_g][l];
    assign w_qx      = {{N_LEN_W{w_q[N_LEN_W-1]}}, w_q};
    assign w_sq_full = w_qx * w_qx;
    assign w_dl      = w_d[r_s2_grp][l];
    assign w_dx      = {{N_LEN_W{w_dl[N_LEN-1]}}, w_dl};
    assign w_derivx  = {{N_LEN{r_s2_deriv[N_LEN_W-1]}}, r_s2_deriv};
    assign w_prod    = w_dx * w_derivx;

`ifdef ACT_BWD_SAT_EN
    localparam logic signed [N_LEN+N_LEN_W-1:0] c_max = {{(N_LEN_W+1){1'b0}}, {(N_LEN-1){1'b1}}};
    localparam logic signed [N_LEN+N_LEN_W-1:0] c_min = {{(N_LEN_W+1){1'b1}}, {(N_LEN-1){1'b0}}};
    logic signed [N_LEN+N_LEN_W-1:0] w_shift;
    assign w_shift = w_prod >>> c_shift;
    assign w_res   = (w_shift > c_max) ? N_LEN'(c_max) :
                     (w_shift < c_min) ? N_LEN'(c_min) : N_LEN'(w_shift);
`else
    assign w_res   = N_LEN'(w_prod >>> c_shift);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s1_q     <= '0;
        r_s1_sq    <= '0;
        r_s2_deriv <= '0;
        r_s3_res   <= '0;
      end else begin
        r_s1_q     <= w_q;
        r_s1_sq    <= N_LEN_W'(w_sq_full >>> F_LEN_W);
        r_s2_deriv <= r_mode ? (r_s1_q - r_s1_sq) : (c_one - r_s1_sq);
        r_s3_res   <= w_res;
      end
    end

    assign w_s3_res[l] = r_s3_res;
  end

  // One result slot per element; only the slots of the retiring group update
  for (genvar e = 0; e < DIM; e++) begin : g_slot
    localparam logic [c_gw-1:0] c_grp = c_gw'(e / LANES);
    logic [N_LEN-1:0] r_slot;

    assign w_qf[e / LANES][e % LANES] = q_forward[e*N_LEN_W +: N_LEN_W];
    assign w_d[e / LANES][e % LANES]  = d[e*N_LEN +: N_LEN];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        r_slot <= '0;
      else if (!clear && r_s3_vld && (r_s3_grp == c_grp))
        r_slot <= w_s3_res[e % LANES];
    end

    assign q_backward[e*N_LEN +: N_LEN] = r_slot;
  end

endmodule
`default_nettype wire

// File: tb/tb_act_backward_block.sv
`default_nettype none
// ============================================================================
// Module  : tb_act_backward_block
// Brief   : Directed self-checking bench for act_backward_block.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_act_backward_block;

  localparam int DIM = 32;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               clear = 1'b0;
  logic               mode = 1'b0;
  logic [DIM*16-1:0]  d = '0;
  logic [DIM*16-1:0]  q_forward = '0;
  logic               busy, valid;
  logic [DIM*16-1:0]  q_backward;

  int n_cmp  = 0;
  int n_fail = 0;
  int qv [DIM];
  int dv [DIM];
  int lat;

  act_backward_block dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .clear      (clear),
    .mode       (mode),
    .d          (d),
    .q_forward  (q_forward),
    .busy       (busy),
    .valid      (valid),
    .q_backward (q_backward)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack();
    for (int i = 0; i < DIM; i++) begin
      q_forward[i*16 +: 16] = 16'(qv[i]);
      d[i*16 +: 16]         = 16'(dv[i]);
    end
  endtask

  task automatic set_all(input int q, input int dd);
    for (int i = 0; i < DIM; i++) begin
      qv[i] = q;
      dv[i] = dd;
    end
    pack();
  endtask

  // Drive start for one edge (E0), then count edges until valid is seen
  task automatic run(input bit m, output int n);
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n = 1;
    while (!valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic check_const(input string tag, input logic [15:0] exp);
    for (int i = 0; i < DIM; i++)
      chk(tag, {16'd0, q_backward[i*16 +: 16]}, {16'd0, exp});
  endtask

  // Reference arithmetic: wrap S1/S2 to 16 bits, floor-shift the final product
  function automatic logic [15:0] model(input int q, input int dd, input bit m);
    logic signed [15:0] t;
    int sq, dr, r;
    t  = 16'((q * q) >>> 13);
    sq = int'(t);
    dr = m ? (q - sq) : (8192 - sq);
    t  = 16'(dr);
    dr = int'(t);
    r  = (dd * dr) >>> 13;
`ifdef ACT_BWD_SAT_EN
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
`endif
    return 16'(r);
  endfunction

  initial begin
    // Reset state
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    n_cmp++;
    assert (q_backward === '0) else begin
      n_fail++;
      $error("FAIL rst_qb: observed %0h expected 0", q_backward);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Tanh basics
    set_all(0, 256);
    run(1'b0, lat);
    chk("lat_tanh0", lat, 11);
    check_const("tanh_q0", 16'd256);

    set_all(4096, 256);
    run(1'b0, lat);
    chk("lat_b2b", lat, 11);
    check_const("tanh_q05", 16'd192);

    set_all(4096, -256);
    run(1'b0, lat);
    check_const("tanh_neg", 16'(-192));

    // Sigmoid
    set_all(4096, 256);
    run(1'b1, lat);
    check_const("sig_q05", 16'd64);
    set_all(8192, 256);
    run(1'b1, lat);
    check_const("sig_q1", 16'd0);

    // Latency/handshake with per-element pattern, restart from DONE
    for (int i = 0; i < DIM; i++) begin
      qv[i] = (i - 16) * 512;
      dv[i] = i * 97 - 1500;
    end
    pack();
    mode  = 1'b0;
    start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    chk("e0_busy", {31'd0, busy}, 32'd0);
    chk("e0_valid", {31'd0, valid}, 32'd1);
    tick();                                   // E1
    chk("e1_busy", {31'd0, busy}, 32'd1);
    chk("e1_valid", {31'd0, valid}, 32'd0);
    tick(); tick(); tick();                   // E4
    start = 1'b1;
    mode  = 1'b1;
    tick();                                   // E5: ignored start
    start = 1'b0;
    mode  = 1'b0;
    for (int k = 6; k <= 10; k++) tick();     // E10
    chk("e10_busy", {31'd0, busy}, 32'd1);
    chk("e10_valid", {31'd0, valid}, 32'd0);
    tick();                                   // E11
    chk("e11_busy", {31'd0, busy}, 32'd0);
    chk("e11_valid", {31'd0, valid}, 32'd1);
    for (int i = 0; i < DIM; i++)
      chk("pattern", {16'd0, q_backward[i*16 +: 16]}, {16'd0, model(qv[i], dv[i], 1'b0)});
    tick(); tick();
    chk("done_hold_valid", {31'd0, valid}, 32'd1);
    chk("done_hold_busy", {31'd0, busy}, 32'd0);

    // Overflow
    set_all(12288, -32512);
    run(1'b0, lat);
`ifdef ACT_BWD_SAT_EN
    check_const("ovf", 16'd32767);
`else
    check_const("ovf", 16'(-24896));
`endif

    // Abort and restart
    set_all(0, 256);
    run(1'b0, lat);
    check_const("pre_abort", 16'd256);
    set_all(0, 512);
    start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    for (int k = 1; k <= 5; k++) tick();      // E5
    clear = 1'b1;
    tick();                                   // E6
    clear = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_valid", {31'd0, valid}, 32'd0);
    for (int k = 0; k < 6; k++) tick();
    chk("abort_valid_late", {31'd0, valid}, 32'd0);
    chk("abort_busy_late", {31'd0, busy}, 32'd0);
    for (int i = 0; i < DIM; i++)
      chk("abort_slots", {16'd0, q_backward[i*16 +: 16]}, (i < 8) ? 32'd512 : 32'd256);
    run(1'b0, lat);
    chk("lat_restart", lat, 11);
    check_const("restart", 16'd512);

    // clear and start together
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    chk("cs_valid", {31'd0, valid}, 32'd0);
    tick(); tick(); tick();
    chk("cs_busy", {31'd0, busy}, 32'd0);
    chk("cs_valid_late", {31'd0, valid}, 32'd0);
    chk("cs_keep", {16'd0, q_backward[15:0]}, 32'd512);

    // Asynchronous reset during RUN
    set_all(4096, 256);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);
    n_cmp++;
    assert (q_backward === '0) else begin
      n_fail++;
      $error("FAIL mid_rst_qb: observed %0h expected 0", q_backward);
    end
    tick();
    rst_n = 1'b1;
    tick();
    run(1'b0, lat);
    chk("lat_post_rst", lat, 11);
    check_const("post_rst", 16'd192);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/act_backward_block.md
# act_backward_block

Parametrised backward pass for the element-wise activation layer in the training datapath. Computes the input gradient from the upstream gradient `d` and the stored forward output `q_forward`, with run-time selection between tanh and sigmoid derivatives. Elements are processed `LANES` at a time through a 3-stage multiply pipeline. The result is presented as a flat vector with a start/valid handshake to the layer sequencer.

## Interface
Parameters:
- `DIM`, 32: vector length. Must be a multiple of `LANES`.
- `LANES`, 4: elements processed per cycle. `G = DIM/LANES` groups.
- `N_LEN`, 16: width of `d` and `q_backward`, signed fixed point.
- `F_LEN`, 8: fraction bits of `d` and `q_backward`.
- `N_LEN_W`, 16: width of `q_forward`, signed fixed point.
- `F_LEN_W`, 13: fraction bits of `q_forward`. Requires `N_LEN_W - F_LEN_W >= 2`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle run request.
- `clear` in 1: synchronous abort; returns the block to IDLE.
- `mode` in 1: 0 = tanh, where deriv = 1 − q². 1 = sigmoid, where deriv = q − q². Sampled with `start`.
- `d` in `DIM*N_LEN`: upstream gradient. Element i is at `[i*N_LEN +: N_LEN]`.
- `q_forward` in `DIM*N_LEN_W`: forward activation output, same packing.
- `busy` out 1: high while a run is in progress.
- `valid` out 1: level signal; high while `q_backward` holds a complete result.
- `q_backward` out `DIM*N_LEN`: gradient result, same packing.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on `start`.
  - RUN→DONE when the last group is written.
  - DONE→RUN on `start`.
  - Any state→IDLE on `clear`. `clear` has priority over `start`.
- `start` is ignored in RUN. `mode` is latched on an accepted `start` and held for the whole run.
- `d` and `q_forward` must be stable from the accepted `start` until `valid` rises. They are not captured.
- Group counter `g` runs 0..G−1, one step per cycle, and saturates at G−1. Group g covers elements `g*LANES .. g*LANES+LANES−1`.
- Pipeline, per lane:
  - S1: `sq = fmul_w(q, q)`. `fmul_w` takes the signed 2·N_LEN_W product and keeps bits `[F_LEN_W +: N_LEN_W]`.
  - S2: `deriv = ONE − sq` for tanh, or `q − sq` for sigmoid. `ONE = 1 << F_LEN_W`. `q` is delayed to align with `sq`. Subtraction is modulo 2^N_LEN_W.
  - S3: the signed product `d × deriv` (N_LEN+N_LEN_W bits) is arithmetically shifted right by F_LEN_W, i.e. truncated toward −∞. The N_LEN-bit result is written to the `q_backward` slots of that group.
- The group index travels with the data through each stage. Writes are enabled only for groups belonging to the current run.
- `q_backward` slots are not cleared on `start` or `clear`. They keep their old values until overwritten.
- Reset mid-run forces IDLE immediately, and all outputs return to reset values.

## Timing
- Reset values: `busy`=0, `valid`=0, `q_backward`=0, FSM=IDLE, `g`=0, all pipeline registers 0.
- Let E0 be the edge that samples `start`.
  - Group k is issued in cycle k+1.
  - Group k is written at edge E(k+4).
- The last group is written at E(G+3). At that same edge, `valid` rises and `busy` falls, so latency is G+3 cycles.
- `busy` rises at E1.
- `valid` stays high in DONE until `clear`, a new `start`, or reset. On a restart it falls at E1.
- Back-to-back runs: `start` is accepted in the first DONE cycle.
- `clear` in RUN: writes still in the pipeline are suppressed, and `busy` falls at the next edge.

## Configuration
- `ACT_BWD_SAT_EN`:
  - Defined: the S3 shifted product is saturated to [−2^(N_LEN−1), 2^(N_LEN−1)−1] before truncation to N_LEN bits.
  - Undefined: the low N_LEN bits are kept and the value wraps.
  - S1 and S2 wrap in both builds.

## Test plan
All scenarios use the default parameters, so ONE = 8192 and d = 1.0 is 256.
- Tanh basics, all elements: q=0, d=256 → 256; q=4096 (0.5), d=256 → 192; q=4096, d=−256 → −192.
- Sigmoid: q=4096, d=256, mode=1 → 64. Then q=8192, d=256 → 0.
- Latency and handshake: `start` at E0 → `busy` high at E1, `valid` high at E11 (G=8). All 32 outputs are correct, with a distinct per-element pattern. A `start` issued mid-run is ignored.
- Overflow: q=12288 (1.5), tanh, d=−32512 → 32767 with `ACT_BWD_SAT_EN` defined, −24896 without.
- Abort and restart:
  - `clear` at E5 → `busy` low at E6, `valid` stays 0, slots for groups not yet written keep their old values.
  - A following `start` → correct full result at the new E(G+3).
  - `clear` and `start` in the same cycle → the block stays in IDLE.
- Reset: assert `rst_n` low during RUN → `busy`, `valid` and `q_backward` are 0 immediately. Apply `start` after release → normal run.
